// File: rtl/obi_bank_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate among NumMgr managers, with
// request locking, manager-index tagging of aid and in-order response routing.
module obi_bank_arbiter #(
  parameter int NumMgr    = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1,
  parameter int MaxTrans  = 2,
  localparam int IdxW     = (NumMgr > 1) ? $clog2(NumMgr) : 1,
  localparam int SbrIdW   = IdxW + IdWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumMgr-1:0]             mgr_req_i,
  input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
  input  logic [NumMgr-1:0]             mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
  input  logic [NumMgr*IdWidth-1:0]     mgr_aid_i,
  output logic [NumMgr-1:0]             mgr_gnt_o,
  output logic [NumMgr-1:0]             mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic [IdWidth-1:0]            mgr_rid_o,
  output logic                          mgr_err_o,
  output logic                          sbr_req_o,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  output logic [SbrIdW-1:0]             sbr_aid_o,
  input  logic                          sbr_gnt_i,
  input  logic                          sbr_rvalid_i,
  input  logic [DataWidth-1:0]          sbr_rdata_i,
  input  logic [SbrIdW-1:0]             sbr_rid_i,
  input  logic                          sbr_err_i,
  output logic                          proto_err_o
);

  localparam int BeW  = DataWidth / 8;
  localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW = $clog2(MaxTrans + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxTrans);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);
  localparam logic [IdxW-1:0] LastMgr = IdxW'(NumMgr - 1);
  localparam logic [IdxW:0]   NumW    = (IdxW + 1)'(NumMgr);

  logic [IdxW-1:0] rr_ptr;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] fifo_q [MaxTrans];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count_q;
  logic            proto_err_q;

  logic [IdxW-1:0] winner;
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;
  logic            sbr_req;
  logic            hs;
  logic            pop;
  logic [IdxW-1:0] head;
  logic            sel;
  logic            unused_rid;

  // Winner selection: locked index, else first requester at or after rr_ptr.
  // Scanning offsets high-to-low lets the lowest offset overwrite last.
  always_comb begin
    winner = rr_ptr;
    sum    = '0;
    cand   = '0;
    if (lock_q) begin
      winner = lock_idx_q;
    end else begin
      for (int i = NumMgr - 1; i >= 0; i--) begin
        sum    = {1'b0, rr_ptr} + (IdxW + 1)'(i);
        sum    = (sum >= NumW) ? (sum - NumW) : sum;
        cand   = sum[IdxW-1:0];
        winner = mgr_req_i[cand] ? cand : winner;
      end
    end
  end

  // Request, handshake and response-pop qualifiers; full check uses registered count.
  always_comb begin
    sbr_req = (lock_q | (|mgr_req_i)) & (count_q != MaxCnt);
    hs      = sbr_req & sbr_gnt_i;
    pop     = sbr_rvalid_i & (count_q != '0);
    head    = fifo_q[rd_ptr];
  end

  // A-channel AND-OR mux from the winner, per-manager grant and rvalid decode.
  always_comb begin
    sbr_addr_o   = '0;
    sbr_we_o     = 1'b0;
    sbr_be_o     = '0;
    sbr_wdata_o  = '0;
    sbr_aid_o    = '0;
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    sel          = 1'b0;
    for (int i = 0; i < NumMgr; i++) begin
      sel             = sbr_req & (winner == IdxW'(i));
      sbr_addr_o      = sbr_addr_o  | ({AddrWidth{sel}} & mgr_addr_i[i*AddrWidth +: AddrWidth]);
      sbr_we_o        = sbr_we_o    | (sel & mgr_we_i[i]);
      sbr_be_o        = sbr_be_o    | ({BeW{sel}} & mgr_be_i[i*BeW +: BeW]);
      sbr_wdata_o     = sbr_wdata_o | ({DataWidth{sel}} & mgr_wdata_i[i*DataWidth +: DataWidth]);
      sbr_aid_o       = sbr_aid_o   | ({SbrIdW{sel}} & {IdxW'(i), mgr_aid_i[i*IdWidth +: IdWidth]});
      mgr_gnt_o[i]    = sel & sbr_gnt_i;
      mgr_rvalid_o[i] = pop & (head == IdxW'(i));
    end
  end

  assign sbr_req_o   = sbr_req;
  assign mgr_rdata_o = sbr_rdata_i;
  assign mgr_err_o   = sbr_err_i;
  assign mgr_rid_o   = sbr_rid_i[IdWidth-1:0];
  assign proto_err_o = proto_err_q;
  assign unused_rid  = ^sbr_rid_i[SbrIdW-1:IdWidth];

  // Arbitration state, outstanding-index FIFO and sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr      <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
      for (int k = 0; k < MaxTrans; k++) begin
        fifo_q[k] <= '0;
      end
    end else begin
      if (hs) begin
        fifo_q[wr_ptr] <= winner;
        wr_ptr         <= (wr_ptr == LastPtr) ? '0 : wr_ptr + PtrW'(1);
        rr_ptr         <= (winner == LastMgr) ? '0 : winner + IdxW'(1);
        lock_q         <= 1'b0;
      end else if (sbr_req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= winner;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + PtrW'(1);
      end
      count_q <= count_q + CntW'(hs) - CntW'(pop);
      if (sbr_rvalid_i && (count_q == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule
